mul_seq_w: RTL and testbench
============================

# mul_seq_w

Parametrised sequential W×W multiplier for signed and unsigned operands. It replaces the fully combinational 8-bit signed array multiplier where area matters more than latency. It uses one adder, one accumulator and a W-step shift-add loop. Operands and results move over valid/ready handshakes, so the block can sit directly in a datapath pipeline with backpressure.

## Interface
- W, default 8: operand width in bits; legal range 2..32.
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair on a/b/is_signed is valid.
- in_ready  output  1  block can accept operands this cycle.
- a  input  W  multiplicand.
- b  input  W  multiplier.
- is_signed  input  1  1 = both operands two's complement; 0 = both unsigned.
- out_valid  output  1  y holds a finished product.
- out_ready  input  1  consumer accepts y this cycle.
- y  output  2W  product, exact (no truncation or overflow possible).
- busy  output  1  high in RUN and DONE.

## Operation
- The FSM has three states: IDLE, RUN and DONE. The reset state is IDLE.
- **IDLE**
  - in_ready=1.
  - When in_valid=1, latch a, b and is_signed, clear acc (2W bits) and step counter (clog2(W) bits), then go to RUN.
- **RUN**
  - in_ready=0. One step per cycle, for step i = 0..W-1.
  - Let a_ext = a sign-extended to 2W bits if is_signed, else zero-extended.
  - Step i < W-1: if b[i]=1, acc += a_ext << i.
  - Step i = W-1:
    - if b[W-1]=1 and is_signed=1, acc -= a_ext << (W-1);
    - if b[W-1]=1 and is_signed=0, acc += a_ext << (W-1).
  - All arithmetic is modulo 2^(2W).
  - After step W-1, copy acc to y and go to DONE.
- **DONE**
  - out_valid=1, in_ready=0.
  - y and out_valid stay stable until out_ready=1.
  - On out_valid && out_ready, go to IDLE.
- Operand inputs are sampled only on the accept edge; later changes have no effect on a product in flight.
- y changes only on the RUN→DONE transition. It keeps its last value in IDLE and RUN.
- Result equals the mathematical product of the operands as interpreted by is_signed, represented in 2W bits.

## Timing
- **Reset values:** in_ready=0 during the reset cycle, then 1; out_valid=0; busy=0; y=0; acc=0; counter=0; state=IDLE.
- **Accept:** in_valid && in_ready sampled at edge E0.
- **Compute:** RUN occupies the W cycles after E0; step i executes at edge E(i+1).
- **Result:** out_valid first high in the cycle after edge EW. Latency is W cycles from accept to out_valid.
- **Throughput:** at most one product per W+2 cycles, i.e. accept, W steps, one DONE cycle, then return to IDLE. in_ready is asserted in the cycle after the output handshake.
- **Backpressure:** with out_ready held low, DONE lasts indefinitely. in_ready stays 0 and no new operands are accepted.
- **in_valid outside IDLE:** ignored and not queued.
- **Reset mid-operation:** rst=1 at any edge, in any state, forces IDLE and all reset values at that edge. The partial product is discarded and no out_valid is produced for it.
- **rst and in_valid together:** reset wins; the operands are not accepted.

## Test plan
- W=8, signed, a=0x80 (−128), b=0x80 (−128) → y=0x4000; out_valid exactly 8 cycles after accept.
- W=8, signed, a=0xFF (−1), b=0x7F → y=0xFF81. Then unsigned with the same operands → y=0x7E81.
- W=8, unsigned, a=0xFF, b=0xFF → y=0xFE01. Then signed with the same operands → y=0x0001.
- Backpressure, W=8, signed, a=5, b=−3:
  - hold out_ready=0 for 5 cycles after out_valid → y=0xFFF1 stable, in_ready=0, busy=1 throughout;
  - in_valid pulses in that window are ignored;
  - out_ready=1 → in_ready=1 the next cycle.
- Reset mid-RUN: assert rst at step 3 → the next cycle shows state IDLE, out_valid=0, y=0, in_ready=1. A fresh a=3, b=4 then yields y=12.
- W=16 and W=2: 1000 random operand pairs with random is_signed, random in_valid and out_ready gaps. Every y matches the reference product, and each product appears exactly once per accept.

Source files
------------

// File: rtl/mul_seq_w.sv
// rtl/mul_seq_w.sv - sequential shift-add WxW multiplier, signed/unsigned, valid/ready handshakes
module mul_seq_w #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           is_signed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] y,
  output logic           busy
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic           sgn_q;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] acc_next;
  logic [2*W-1:0] a_ext;
  logic [2*W-1:0] term;
  logic [CW-1:0]  cnt;
  logic           last_step;
  logic           b_bit;
  logic           accept;

  // Step datapath: the MSB of a signed multiplier carries weight -2^(W-1), so the final step subtracts
  always_comb begin
    a_ext     = sgn_q ? {{W{a_q[W-1]}}, a_q} : {{W{1'b0}}, a_q};
    term      = a_ext << cnt;
    b_bit     = b_q[cnt];
    last_step = (cnt == LAST);
    acc_next  = acc;
    if (b_bit) begin
      if (last_step && sgn_q) begin
        acc_next = acc - term;
      end else begin
        acc_next = acc + term;
      end
    end
  end

  // State register; reset forces IDLE from any state
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs; in_ready is held low while reset is asserted
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        busy     = 1'b0;
        in_ready = ~rst;
        accept   = in_valid;
        if (in_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        busy       = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture, accumulation and result register; y only moves on the last step
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
      y     <= '0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      sgn_q <= is_signed;
      acc   <= '0;
      cnt   <= '0;
    end else if (state == RUN) begin
      acc <= acc_next;
      cnt <= cnt + 1'b1;
      if (last_step) begin
        y <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_mul_seq_w.sv
// tb/tb_mul_seq_w.sv - self-checking bench for mul_seq_w at W=8, W=16 and W=2
module tb_mul_seq_w;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  iv;
  logic [2:0]  ir;
  logic [2:0]  ov;
  logic [2:0]  ordy;
  logic [2:0]  bz;
  logic [2:0]  sv;
  logic [31:0] av [3];
  logic [31:0] bv [3];
  logic [15:0] y8;
  logic [31:0] y16;
  logic [3:0]  y2;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    bit          s;
    logic [15:0] y;
  } vec_t;

  localparam int NV = 10;
  vec_t tbl [NV];

  always #5 clk = ~clk;

  mul_seq_w #(.W(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(av[0][7:0]), .b(bv[0][7:0]), .is_signed(sv[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .y(y8), .busy(bz[0])
  );

  mul_seq_w #(.W(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(av[1][15:0]), .b(bv[1][15:0]), .is_signed(sv[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .y(y16), .busy(bz[1])
  );

  mul_seq_w #(.W(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(av[2][1:0]), .b(bv[2][1:0]), .is_signed(sv[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .y(y2), .busy(bz[2])
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      passed++;
    end
  endtask

  function automatic logic [63:0] get_y(input int k);
    case (k)
      0:       return {48'b0, y8};
      1:       return {32'b0, y16};
      default: return {60'b0, y2};
    endcase
  endfunction

  // Mathematical product of the operands as interpreted at width w, kept to 2w bits
  function automatic logic [63:0] ref_prod(input int w, input logic [31:0] x,
                                           input logic [31:0] z, input bit s);
    longint m, xa, za, p;
    m  = (longint'(1) << w) - 1;
    xa = longint'({32'b0, x}) & m;
    za = longint'({32'b0, z}) & m;
    if (s) begin
      if (xa >= (longint'(1) << (w - 1))) xa = xa - (longint'(1) << w);
      if (za >= (longint'(1) << (w - 1))) za = za - (longint'(1) << w);
    end
    p = xa * za;
    return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  task automatic run_op(input int k, input logic [31:0] x, input logic [31:0] z, input bit s,
                        output logic [63:0] res, output int lat);
    int n;
    @(negedge clk);
    av[k] = x; bv[k] = z; sv[k] = s; iv[k] = 1'b1; ordy[k] = 1'b1;
    n = 0;
    while (!ir[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ir[k]) chk("op_accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    @(negedge clk);
    iv[k] = 1'b0; av[k] = $urandom; bv[k] = $urandom; sv[k] = ~s;
    lat = 0;
    while (!ov[k] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = get_y(k);
    @(posedge clk);
    @(negedge clk);
    chk("op_ready_after_hs", ir[k], 1);
    chk("op_valid_after_hs", ov[k], 0);
  endtask

  task automatic rand_run(input int k, input int w, input int n);
    logic [63:0] q [$];
    logic [31:0] mask;
    int got;
    int extra;
    mask = (32'd1 << w) - 32'd1;
    got  = 0;
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < n; i++) begin
          int gap;
          int t;
          logic [31:0] x;
          logic [31:0] z;
          bit s;
          gap = $urandom_range(0, 3);
          repeat (gap) @(negedge clk);
          x = $urandom & mask;
          z = $urandom & mask;
          s = 1'($urandom_range(0, 1));
          av[k] = x; bv[k] = z; sv[k] = s; iv[k] = 1'b1;
          t = 0;
          while (!ir[k] && t < 200) begin
            @(negedge clk);
            t++;
          end
          if (!ir[k]) begin
            chk("rand_accept_timeout", 64'd0, 64'd1);
            break;
          end
          q.push_back(ref_prod(w, x, z, s));
          @(negedge clk);
          iv[k] = 1'b0; av[k] = $urandom; bv[k] = $urandom;
        end
      end
      begin
        int cyc;
        cyc = 0;
        while (got < n && cyc < 40000) begin
          @(negedge clk);
          cyc++;
          ordy[k] = ($urandom_range(0, 2) != 0);
          if (ov[k] && ordy[k]) begin
            if (q.size() == 0) chk("rand_spurious_out", 64'd1, 64'd0);
            else chk($sformatf("rand_w%0d_prod%0d", w, got), get_y(k), q.pop_front());
            got++;
          end
        end
        chk($sformatf("rand_w%0d_count", w), got, n);
      end
    join
    iv[k] = 1'b0;
    ordy[k] = 1'b1;
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (ov[k]) extra++;
    end
    chk($sformatf("rand_w%0d_no_extra", w), extra, 0);
    chk($sformatf("rand_w%0d_queue_empty", w), q.size(), 0);
  endtask

  initial begin
    logic [63:0] r;
    int lat;
    int n;
    int seen;

    tbl[0] = '{8'h80, 8'h80, 1'b1, 16'h4000};
    tbl[1] = '{8'hFF, 8'h7F, 1'b1, 16'hFF81};
    tbl[2] = '{8'hFF, 8'h7F, 1'b0, 16'h7E81};
    tbl[3] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    tbl[4] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
    tbl[5] = '{8'h05, 8'hFD, 1'b1, 16'hFFF1};
    tbl[6] = '{8'h7F, 8'h80, 1'b1, 16'hC080};
    tbl[7] = '{8'h80, 8'h7F, 1'b1, 16'hC080};
    tbl[8] = '{8'h00, 8'hFF, 1'b1, 16'h0000};
    tbl[9] = '{8'h03, 8'h04, 1'b0, 16'h000C};

    rst = 1'b1; iv = '0; ordy = '0; sv = '0;
    for (int i = 0; i < 3; i++) begin
      av[i] = '0;
      bv[i] = '0;
    end

    repeat (2) @(negedge clk);
    chk("reset_in_ready", ir[0], 0);
    chk("reset_out_valid", ov[0], 0);
    chk("reset_busy", bz[0], 0);
    chk("reset_y", get_y(0), 0);
    rst = 1'b0;
    #1;
    chk("post_reset_in_ready", ir[0], 1);

    for (int i = 0; i < NV; i++) begin
      run_op(0, {24'b0, tbl[i].a}, {24'b0, tbl[i].b}, tbl[i].s, r, lat);
      chk($sformatf("vec%0d_y", i), r, {48'b0, tbl[i].y});
      chk($sformatf("vec%0d_latency", i), lat, 8);
    end

    @(negedge clk);
    av[0] = 32'h05; bv[0] = 32'hFD; sv[0] = 1'b1; iv[0] = 1'b1; ordy[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    n = 0;
    while (!ov[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_latency", n, 8);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_y_%0d", i), get_y(0), 64'hFFF1);
      chk($sformatf("bp_valid_%0d", i), ov[0], 1);
      chk($sformatf("bp_in_ready_%0d", i), ir[0], 0);
      chk($sformatf("bp_busy_%0d", i), bz[0], 1);
      iv[0] = (i % 2 == 0); av[0] = 32'h07; bv[0] = 32'h09;
      @(negedge clk);
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", ir[0], 1);
    chk("bp_release_valid", ov[0], 0);
    chk("bp_release_busy", bz[0], 0);
    chk("bp_y_held_idle", get_y(0), 64'hFFF1);

    av[0] = 32'h55; bv[0] = 32'h33; sv[0] = 1'b0; iv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrun_rst_in_ready_low", ir[0], 0);
    chk("midrun_rst_y", get_y(0), 0);
    chk("midrun_rst_valid", ov[0], 0);
    chk("midrun_rst_busy", bz[0], 0);
    rst = 1'b0;
    #1;
    chk("midrun_rst_in_ready", ir[0], 1);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (ov[0]) seen++;
    end
    chk("midrun_no_output", seen, 0);
    run_op(0, 32'd3, 32'd4, 1'b0, r, lat);
    chk("after_rst_y", r, 64'd12);
    chk("after_rst_latency", lat, 8);

    @(negedge clk);
    rst = 1'b1; iv[0] = 1'b1; av[0] = 32'h11; bv[0] = 32'h22;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; iv[0] = 1'b0;
    #1;
    chk("rst_wins_busy", bz[0], 0);
    chk("rst_wins_in_ready", ir[0], 1);

    rand_run(1, 16, 1000);
    rand_run(2, 2, 1000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
